// File: rtl/bcorrect_pkg.sv
// bcorrect_pkg: record layout constants and channel extraction helper
package bcorrect_pkg;
    localparam int PC_W_DEF    = 32;
    localparam int POS_W_DEF   = 8;
    localparam int REC_W       = 2 + PC_W_DEF + POS_W_DEF;
    localparam int VALID_BIT   = REC_W - 1;
    localparam int MISPRED_BIT = REC_W - 2;
    localparam int PC_LSB      = POS_W_DEF;
    localparam int BUS_MAX     = 1024;

    function automatic logic [BUS_MAX-1:0] get_rec(input logic [BUS_MAX-1:0] bus, input int c, input int rec_w);
        return bus >> (c * rec_w);
    endfunction
endpackage

// File: rtl/bcorrect_fifo.sv
// bcorrect_fifo: power-of-two correction FIFO with push, pop and flush
module bcorrect_fifo #(
    parameter int W     = 40,
    parameter int DEPTH = 4
) (
    input  logic         fire,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         valid,
    output logic         full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          wr, rd;

    assign valid = occ_q != '0;
    assign full  = occ_q == (AW+1)'(DEPTH);
    assign dout  = valid ? mem_q[rptr_q] : '0;

    // a write while full only lands when the head leaves in the same cycle
    always_comb begin
        wr     = push && !flush && (!full || pop);
        rd     = pop && valid && !flush;
        mem_d  = mem_q;
        if (wr) mem_d[wptr_q] = din;
        wptr_d = flush ? '0 : wptr_q + AW'(wr);
        rptr_d = flush ? '0 : rptr_q + AW'(rd);
        occ_d  = flush ? '0 : occ_q + (AW+1)'(wr) - (AW+1)'(rd);
    end

    // pointers and occupancy; reset empties the queue
    always_ff @(posedge fire) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            occ_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            occ_q  <= occ_d;
        end
    end

    // storage needs no reset since the head output is gated when empty
    always_ff @(posedge fire) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/bcorrect_mc.sv
// bcorrect_mc: picks the oldest mispredict per cycle and queues its correction for fetch
module bcorrect_mc
    import bcorrect_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int PC_W     = PC_W_DEF,
    parameter int POS_W    = POS_W_DEF,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3,
    parameter int STORM_TH = 4
) (
    input  logic                               fire,
    input  logic                               rst,
    input  logic                               i_flush,
    input  logic [NUM_CH*(2+PC_W+POS_W)-1:0]   i_data,
    input  logic                               i_ready,
    output logic                               o_valid,
    output logic [PC_W-1:0]                    o_correctpc,
    output logic [POS_W-1:0]                   o_errPos,
    output logic [CNT_W-1:0]                   o_counter,
    output logic                               o_storm,
    output logic                               o_full,
    output logic                               o_overflow,
    output logic [CNT_W-1:0]                   o_drop_cnt
);
    localparam int R_W = 2 + PC_W + POS_W;
    localparam int E_W = PC_W + POS_W;
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic             found, any_valid, push, pop, drop;
    logic [E_W-1:0]   sel_ent, head;
    logic [CNT_W-1:0] cnt_q, cnt_d, drop_q, drop_d;
    logic             ovf_q, ovf_d;

    // scan youngest to oldest so the lowest mispredicting channel wins
    always_comb begin
        logic [R_W-1:0] rec;
        found     = 1'b0;
        any_valid = 1'b0;
        sel_ent   = '0;
        rec       = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            rec = R_W'(get_rec(BUS_MAX'(i_data), c, R_W));
            if (rec[R_W-1]) any_valid = 1'b1;
            if (rec[R_W-1] && rec[R_W-2]) begin
                found   = 1'b1;
                sel_ent = rec[E_W-1:0];
            end
        end
    end

    // streak counter, push/pop decisions and overflow accounting
    always_comb begin
        cnt_d  = found ? (cnt_q == CMAX ? cnt_q : cnt_q + 1'b1) : any_valid ? '0 : cnt_q;
        push   = found && !i_flush;
        pop    = o_valid && i_ready && !i_flush;
        drop   = push && o_full && !pop;
        ovf_d  = drop;
        drop_d = (drop && drop_q != CMAX) ? drop_q + 1'b1 : drop_q;
    end

    // counters and the registered overflow pulse
    always_ff @(posedge fire) begin
        if (!rst) begin
            cnt_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    bcorrect_fifo #(.W(E_W), .DEPTH(DEPTH)) u_fifo (
        .fire  (fire),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (i_flush),
        .din   (sel_ent),
        .dout  (head),
        .valid (o_valid),
        .full  (o_full)
    );

    assign o_correctpc = head[E_W-1:POS_W];
    assign o_errPos    = head[POS_W-1:0];
    assign o_counter   = cnt_q;
    assign o_storm     = int'(cnt_q) >= STORM_TH;
    assign o_overflow  = ovf_q;
    assign o_drop_cnt  = drop_q;
endmodule

// File: tb/tb_bcorrect_mc.sv
// tb_bcorrect_mc: directed vectors for the branch-correction collector
module tb_bcorrect_mc;
    logic        fire = 1'b0;
    logic        rst, i_flush, i_ready;
    logic [83:0] i_data;
    logic        o_valid, o_storm, o_full, o_overflow;
    logic [31:0] o_correctpc;
    logic [7:0]  o_errPos;
    logic [2:0]  o_counter, o_drop_cnt;
    int checks = 0;
    int failures = 0;

    bcorrect_mc dut (
        .fire        (fire),
        .rst         (rst),
        .i_flush     (i_flush),
        .i_data      (i_data),
        .i_ready     (i_ready),
        .o_valid     (o_valid),
        .o_correctpc (o_correctpc),
        .o_errPos    (o_errPos),
        .o_counter   (o_counter),
        .o_storm     (o_storm),
        .o_full      (o_full),
        .o_overflow  (o_overflow),
        .o_drop_cnt  (o_drop_cnt)
    );

    always #5 fire = ~fire;

    function automatic logic [41:0] r(input logic v, input logic m, input logic [31:0] pc, input logic [7:0] pos);
        return {v, m, pc, pos};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge fire);
        #1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 64'(o_valid), 0);
        check({tag, "_pc"}, 64'(o_correctpc), 0);
        check({tag, "_pos"}, 64'(o_errPos), 0);
        check({tag, "_cnt"}, 64'(o_counter), 0);
        check({tag, "_storm"}, 64'(o_storm), 0);
        check({tag, "_full"}, 64'(o_full), 0);
        check({tag, "_ovf"}, 64'(o_overflow), 0);
        check({tag, "_drop"}, 64'(o_drop_cnt), 0);
    endtask

    initial begin
        logic [31:0] drain_pc [4];
        drain_pc = '{32'h102, 32'h103, 32'h200, 32'h0};
        rst = 1'b0; i_flush = 1'b0; i_ready = 1'b0; i_data = '0;
        tick(); tick();
        check_zero("reset");
        rst = 1'b1;

        i_data = {r(1, 1, 32'h1000, 8'h05), 42'b0};
        tick();
        check("ch1_valid", 64'(o_valid), 1);
        check("ch1_pc", 64'(o_correctpc), 64'h1000);
        check("ch1_pos", 64'(o_errPos), 5);
        check("ch1_cnt", 64'(o_counter), 1);
        i_data = '0; i_ready = 1'b1;
        tick();
        check("pop_empty", 64'(o_valid), 0);
        check("idle_hold", 64'(o_counter), 1);

        i_ready = 1'b0;
        i_data = {r(1, 1, 32'hB0, 8'd2), r(1, 1, 32'hA0, 8'd1)};
        tick();
        check("oldest_pc", 64'(o_correctpc), 64'hA0);
        check("oldest_pos", 64'(o_errPos), 1);
        check("oldest_cnt", 64'(o_counter), 2);
        i_ready = 1'b1; i_data = '0;
        tick();
        check("single_push", 64'(o_valid), 0);

        i_ready = 1'b0;
        i_data = {42'b0, r(1, 0, 32'h0, 8'h0)};
        tick();
        check("clear_cnt", 64'(o_counter), 0);
        for (int j = 1; j <= 5; j++) begin
            i_data = {42'b0, r(1, 1, 32'h100 + 32'(j - 1), 8'(j - 1))};
            tick();
            check("fill_cnt", 64'(o_counter), 64'(j));
            check("fill_full", 64'(o_full), 64'(j >= 4));
            check("fill_storm", 64'(o_storm), 64'(j >= 4));
            check("fill_ovf", 64'(o_overflow), 64'(j == 5));
            check("fill_drop", 64'(o_drop_cnt), 64'(j == 5));
        end
        check("fill_head", 64'(o_correctpc), 64'h100);

        i_ready = 1'b1;
        i_data = {42'b0, r(1, 1, 32'h200, 8'd9)};
        tick();
        check("pp_head", 64'(o_correctpc), 64'h101);
        check("pp_pos", 64'(o_errPos), 1);
        check("pp_full", 64'(o_full), 1);
        check("pp_ovf", 64'(o_overflow), 0);
        check("pp_drop", 64'(o_drop_cnt), 1);
        check("pp_cnt", 64'(o_counter), 6);
        i_data = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("drain_pc", 64'(o_correctpc), 64'(drain_pc[k]));
            check("drain_valid", 64'(o_valid), 64'(k < 3));
        end

        i_data = {r(1, 1, 32'h400, 8'h0), 42'b0};
        for (int k = 0; k < 9; k++) tick();
        check("sat_cnt", 64'(o_counter), 7);
        check("sat_storm", 64'(o_storm), 1);
        i_data = '0;
        tick();
        check("sat_hold", 64'(o_counter), 7);
        i_data = {r(1, 0, 32'h0, 8'h0), 42'b0};
        tick();
        check("sat_clear", 64'(o_counter), 0);
        check("sat_storm_off", 64'(o_storm), 0);
        i_data = '0;
        tick();
        check("zero_hold", 64'(o_counter), 0);

        i_ready = 1'b0;
        i_data = {r(1, 1, 32'h500, 8'd7), r(1, 0, 32'h9, 8'd9)};
        tick();
        check("skip_ok_pc", 64'(o_correctpc), 64'h500);
        check("skip_ok_cnt", 64'(o_counter), 1);
        i_data = {42'b0, r(1, 1, 32'h301, 8'd1)};
        tick();
        check("two_q_head", 64'(o_correctpc), 64'h500);
        i_flush = 1'b1;
        i_data = {42'b0, r(1, 1, 32'h302, 8'd2)};
        tick();
        check("flush_valid", 64'(o_valid), 0);
        check("flush_pc", 64'(o_correctpc), 0);
        check("flush_full", 64'(o_full), 0);
        check("flush_ovf", 64'(o_overflow), 0);
        check("flush_cnt", 64'(o_counter), 3);
        i_flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data = {42'b0, r(1, 1, 32'h600 + 32'(k), 8'(k))};
            tick();
        end
        check("refill_full", 64'(o_full), 1);
        check("refill_head", 64'(o_correctpc), 64'h600);
        i_flush = 1'b1;
        i_data = {42'b0, r(1, 1, 32'h604, 8'd4)};
        tick();
        check("flushfull_ovf", 64'(o_overflow), 0);
        check("flushfull_drop", 64'(o_drop_cnt), 1);
        check("flushfull_valid", 64'(o_valid), 0);
        check("flushfull_cnt", 64'(o_counter), 7);
        i_flush = 1'b0;
        i_data = {42'b0, r(1, 1, 32'h700, 8'd3)};
        tick();
        check("post_flush_pc", 64'(o_correctpc), 64'h700);
        rst = 1'b0; i_flush = 1'b1;
        tick();
        check_zero("midrst");
        rst = 1'b1; i_flush = 1'b0; i_data = '0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcorrect_mc.md
# bcorrect_mc

Multi-channel branch-correction collector for the instruction-fetch front end. Each `fire` cycle it accepts up to NUM_CH branch-resolution records, selects the oldest mispredict, and queues its correct PC and error position in a DEPTH-entry FIFO drained by fetch through a valid/ready handshake. It also keeps a saturating consecutive-mispredict counter with a storm flag, and counts corrections dropped on overflow.

## Interface
Parameters:
- NUM_CH, 2: resolution channels per cycle; channel 0 is oldest.
- PC_W, 32: PC width.
- POS_W, 8: error-position width.
- DEPTH, 4: FIFO entries; power of two, at least 2.
- CNT_W, 3: width of the mispredict counter and the drop counter.
- STORM_TH, 4: counter value at and above which o_storm asserts.

Ports:
- fire  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-low.
- i_flush  in  1  clears FIFO contents.
- i_data  in  NUM_CH*(2+PC_W+POS_W)  packed records, channel c at [c*REC_W +: REC_W]. Each record is {valid, mispred, correctpc[PC_W], errPos[POS_W]}, MSB first.
- i_ready  in  1  fetch accepts the FIFO head.
- o_valid  out  1  FIFO not empty.
- o_correctpc  out  PC_W  head correct PC; 0 when empty.
- o_errPos  out  POS_W  head error position; 0 when empty.
- o_counter  out  CNT_W  consecutive-mispredict count.
- o_storm  out  1  o_counter >= STORM_TH.
- o_full  out  1  FIFO holds DEPTH entries.
- o_overflow  out  1  one-cycle pulse when a correction is dropped.
- o_drop_cnt  out  CNT_W  saturating count of dropped corrections.

## Operation
- Selection: sel is the lowest c whose record has valid=1 and mispred=1. Channels younger than sel are ignored.
- Counter, evaluated each edge:
  - sel exists: counter+1, saturating at 2^CNT_W-1.
  - else, any valid record present: counter cleared to 0.
  - else: counter holds.
- i_flush does not affect the counter.
- Push condition: sel exists and i_flush=0.
- Pop condition: o_valid && i_ready && i_flush=0.
- Push while full without a pop: the record is dropped, o_overflow=1 for that cycle, o_drop_cnt+1 (saturating).
- Push and pop in the same cycle while full: both happen, no drop.
- Push and pop in the same cycle while empty: push only, since o_valid=0.
- i_flush=1: pointers and occupancy go to 0 at the edge. A same-cycle push is discarded with no overflow and no drop count. The counter still updates from i_data.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.

## Timing
- Reset (rst=0 at an edge) forces, at that edge:
  - FIFO empty, o_valid=0, o_correctpc=0, o_errPos=0
  - o_counter=0, o_storm=0, o_full=0, o_overflow=0, o_drop_cnt=0
  - rst overrides i_flush and all pushes.
- Latency: a mispredict sampled at edge N into an empty FIFO shows on o_valid/o_correctpc/o_errPos right after edge N, i.e. one cycle.
- Head data comes combinationally from the storage array at the read pointer, gated to 0 when empty.
- o_storm and o_full are decoded from registers; no input-to-output combinational path.
- o_overflow is registered and high for exactly the one cycle after the dropping edge.
- Throughput: one push and one pop per cycle.

## Structure
- Package bcorrect_pkg holds:
  - REC_W = 2+PC_W+POS_W
  - field offsets VALID_BIT, MISPRED_BIT, PC_LSB
  - a function that extracts channel c from i_data
- Sub-module bcorrect_fifo: the parametrised storage, pointers, and occupancy with push/pop/flush. The top level holds selection, counters and overflow logic.

## Test plan
- Reset, then one channel-1 record {1,1,0x0000_1000,0x05}: the next cycle shows o_valid=1, o_correctpc=0x1000, o_errPos=0x05, o_counter=1.
- Channel 0 {1,1,0xA0,1} and channel 1 {1,1,0xB0,2} in the same cycle: only 0xA0 is queued; o_counter increments by 1.
- Five consecutive mispredict cycles with i_ready=0 and DEPTH=4: o_full=1 after the 4th; the 5th gives an o_overflow pulse and o_drop_cnt=1; o_storm=1 from o_counter=4.
- Full FIFO with i_ready=1 and a new mispredict: head pops, new entry is pushed, no overflow, o_full stays 1.
- Nine mispredict cycles then one cycle with a valid correct-prediction record: o_counter saturates at 7, then reads 0; idle cycles with no valid records hold the count.
- i_flush together with a mispredict while 2 entries are queued: next cycle o_valid=0, occupancy 0, o_overflow=0, o_counter incremented. Also assert rst mid-traffic: all outputs return to 0.
